// File: rtl/matrix_pkg.sv
// matrix_pkg: shared bus map, control bits and FSM states for the LED matrix frame buffer
package matrix_pkg;
    localparam int ROWS_DEFAULT = 16;
    localparam logic [4:0] ADR_CTRL = 5'h10;
    localparam logic [4:0] ADR_STATUS = 5'h11;
    localparam int CTRL_SWAP = 0;
    localparam int CTRL_CLEAR = 1;
    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/matrix_fb_regs.sv
// matrix_fb_regs: back-buffer row array with byte-lane writes, row clear and async read mux
// Ports: clk_i/rst_ni clock and async active-low reset; we_i/sel_i/dat_i byte-lane write to row adr_i;
//        clr_i/clr_row_i overwrite one row with CLEAR_VAL; rd_dat_o row adr_i; rows_o all rows flattened.
module matrix_fb_regs
    import matrix_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter logic [31:0] CLEAR_VAL = 32'h0,
    localparam int AW = $clog2(ROWS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AW-1:0]        adr_i,
    input  logic [3:0]           sel_i,
    input  logic [31:0]          dat_i,
    input  logic                 clr_i,
    input  logic [AW-1:0]        clr_row_i,
    output logic [31:0]          rd_dat_o,
    output logic [32*ROWS-1:0]   rows_o
);
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [31:0] row;
        // the clear sweep owns the array, so it wins over a bus write
        always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) row <= '0;
            else if (clr_i && clr_row_i == AW'(r)) row <= CLEAR_VAL;
            else if (we_i && adr_i == AW'(r))
                for (int b = 0; b < 4; b++)
                    if (sel_i[b]) row[8*b +: 8] <= dat_i[8*b +: 8];
        assign rows_o[32*r +: 32] = row;
    end
    assign rd_dat_o = rows_o[32*adr_i +: 32];
endmodule

// File: rtl/matrix_framebuf.sv
// matrix_framebuf: Wishbone-attached double-buffered frame store for the LED matrix scan driver
// Ports: clk_i/rst_ni clock and async active-low reset; cyc_i/stb_i/we_i/adr_i/sel_i/dat_i/dat_o/ack_o
//        Wishbone classic slave; frame_sync_i end-of-frame pulse; fb_o front buffer (row n at [32n+31:32n]);
//        busy_o high while the back buffer is being cleared.
module matrix_framebuf
    import matrix_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter logic [31:0] CLEAR_VAL = 32'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [4:0]           adr_i,
    input  logic [3:0]           sel_i,
    input  logic [31:0]          dat_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    input  logic                 frame_sync_i,
    output logic [32*ROWS-1:0]   fb_o,
    output logic                 busy_o
);
    localparam int AW = $clog2(ROWS);
    state_t state, state_n;
    logic [AW-1:0] clr_row;
    logic [7:0] frame_cnt;
    logic pending, req, wr, ctrl_wr, swap, clr_last;
    logic [31:0] row_rd, rd_data;
    logic [32*ROWS-1:0] back;

    // accesses are held off (not acked) for the whole clear sweep
    assign req = cyc_i & stb_i & ~ack_o & (state == IDLE);
    assign wr = req & we_i;
    assign ctrl_wr = wr & (adr_i == ADR_CTRL);
    assign swap = frame_sync_i & pending & (state == IDLE);
    assign clr_last = clr_row == AW'(ROWS - 1);
    // rows occupy the lower half of the map; everything above STATUS reads as zero
    assign rd_data = !adr_i[4] ? row_rd
                   : adr_i == ADR_STATUS ? {16'h0, frame_cnt, 6'h0, pending, busy_o} : '0;

    matrix_fb_regs #(.ROWS(ROWS), .CLEAR_VAL(CLEAR_VAL)) u_regs (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .we_i(wr & ~adr_i[4]),
        .adr_i(adr_i[AW-1:0]),
        .sel_i(sel_i),
        .dat_i(dat_i),
        .clr_i(state == CLEAR),
        .clr_row_i(clr_row),
        .rd_dat_o(row_rd),
        .rows_o(back)
    );

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state == IDLE ? (ctrl_wr && dat_i[CTRL_CLEAR] ? CLEAR : IDLE)
                                : (clr_last ? IDLE : CLEAR);
        busy_o = state == CLEAR;
    end

    // the swap samples the back buffer before any write on the same edge lands
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            ack_o <= 1'b0;
            dat_o <= '0;
            pending <= 1'b0;
            frame_cnt <= '0;
            clr_row <= '0;
            fb_o <= '0;
        end else begin
            ack_o <= req;
            dat_o <= req && !we_i ? rd_data : '0;
            clr_row <= state == CLEAR && !clr_last ? clr_row + 1'b1 : '0;
            pending <= swap ? 1'b0 : pending | (ctrl_wr & dat_i[CTRL_SWAP]);
            if (swap) begin
                fb_o <= back;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
endmodule

// File: tb/tb_matrix_framebuf.sv
// tb_matrix_framebuf: randomized scoreboard bench for matrix_framebuf against a behavioural frame-store model
module tb_matrix_framebuf;
    import matrix_pkg::*;
    logic clk_i = 0, rst_ni = 1, cyc_i = 0, stb_i = 0, we_i = 0, frame_sync_i = 0;
    logic [4:0] adr_i = 0;
    logic [3:0] sel_i = 0;
    logic [31:0] dat_i = 0, dat_o;
    logic ack_o, busy_o;
    logic [511:0] fb_o;

    always #5 clk_i = ~clk_i;

    matrix_framebuf dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .frame_sync_i(frame_sync_i), .fb_o(fb_o), .busy_o(busy_o)
    );

    typedef struct {logic chk; logic [4:0] adr; logic [31:0] val;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0;
    logic [31:0] back[16], front[16];
    logic pend = 0;
    logic [7:0] cnt = 0;
    longint clr_t = -1000;
    logic prev_ack = 0;
    int busy_run = 0, busy_len_last = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic check_fb(input string nm);
        logic [511:0] x;
        for (int r = 0; r < 16; r++) x[32*r +: 32] = front[r];
        check(nm, fb_o, x);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (ack_o) begin
                check("ack_single_cycle", prev_ack, 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with no outstanding access");
                end else begin
                    e = q.pop_front();
                    if (e.chk) check($sformatf("read_adr_%0h", e.adr), dat_o, e.val);
                end
            end else check("dat_idle_zero", dat_o, 0);
            if (busy_o) busy_run++;
            else if (busy_run != 0) begin
                busy_len_last = busy_run;
                busy_run = 0;
            end
        end
        prev_ack = ack_o;
    end

    task automatic bus(input logic w, input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                       output int lat, output logic busy_at_ack);
        exp_t x;
        x.chk = !w;
        x.adr = a;
        x.val = 0;
        if (!w) x.val = a < 16 ? back[a] : a == ADR_STATUS ? {16'h0, cnt, 6'h0, pend, 1'b0} : 32'h0;
        else if (a < 16)
            for (int b = 0; b < 4; b++) if (s[b]) back[a][8*b +: 8] = d[8*b +: 8];
        q.push_back(x);
        @(posedge clk_i);
        #1 cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; sel_i = s; dat_i = d;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!ack_o && lat < 64);
        busy_at_ack = busy_o;
        if (!ack_o) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: adr %0h got no ack within %0d cycles", a, lat);
            void'(q.pop_back());
        end else if (w && a == ADR_CTRL) begin
            if (d[CTRL_CLEAR]) begin
                for (int r = 0; r < 16; r++) back[r] = 32'h0;
                clr_t = longint'($time);
            end
            if (d[CTRL_SWAP]) pend = 1;
        end
        @(posedge clk_i);
        #1 cyc_i = 0; stb_i = 0; we_i = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        int l;
        logic b;
        bus(1, a, s, d, l, b);
    endtask

    task automatic rd(input logic [4:0] a);
        int l;
        logic b;
        bus(0, a, 4'hF, 32'h0, l, b);
    endtask

    // swap only if a request is pending and the sampling cycle lies outside the clear window
    task automatic pulse();
        longint neg;
        @(posedge clk_i);
        #1 frame_sync_i = 1;
        neg = longint'($time) + 4;
        if (pend && !(neg >= clr_t && neg <= clr_t + 150)) begin
            front = back;
            pend = 0;
            cnt = cnt + 8'd1;
        end
        @(posedge clk_i);
        #1 frame_sync_i = 0;
        @(negedge clk_i);
        check_fb("fb_after_sync");
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #7 rst_ni = 0;
        for (int r = 0; r < 16; r++) begin
            back[r] = 0;
            front[r] = 0;
        end
        pend = 0;
        cnt = 0;
        clr_t = -1000;
        q.delete();
        #15 rst_ni = 1;
        #1;
        check_fb("reset_fb");
        check("reset_ack", ack_o, 0);
        check("reset_busy", busy_o, 0);
    endtask

    initial begin
        int lat;
        logic bsy;
        do_reset();
        rd(ADR_STATUS);

        bus(1, 5'd3, 4'hF, 32'hDEADBEEF, lat, bsy);
        check("idle_ack_latency", lat, 2);
        wr(5'd3, 4'b0001, 32'h000000AA);
        rd(5'd3);
        @(negedge clk_i) check_fb("fb_row3_unswapped");

        wr(5'd0, 4'hF, 32'h80000001);
        wr(ADR_CTRL, 4'hF, 32'h1);
        rd(ADR_STATUS);
        pulse();
        rd(ADR_STATUS);
        rd(ADR_CTRL);

        for (int r = 0; r < 16; r++) wr(5'(r), 4'hF, 32'hFFFFFFFF);
        wr(ADR_CTRL, 4'hF, 32'h2);
        bus(1, 5'd5, 4'hF, 32'h12345678, lat, bsy);
        check("stalled_busy_at_ack", bsy, 0);
        check("stalled_ack_latency", lat, 16);
        check("clear_busy_cycles", busy_len_last, 16);
        for (int r = 0; r < 16; r++) rd(5'(r));
        @(negedge clk_i) check_fb("fb_after_clear");

        wr(ADR_CTRL, 4'hF, 32'h3);
        pulse();
        repeat (20) @(posedge clk_i);
        pulse();
        rd(ADR_STATUS);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: wr(5'($urandom_range(0, 15)), 4'($urandom), $urandom);
                4: wr(5'($urandom_range(16, 31)), 4'hF, $urandom);
                5, 6: rd(5'($urandom_range(0, 31)));
                7: wr(ADR_CTRL, 4'hF, $urandom_range(0, 3));
                8: pulse();
                default: rd(ADR_STATUS);
            endcase
            @(negedge clk_i) check_fb("fb_random");
        end

        do_reset();
        for (int i = 0; i < 256; i++) begin
            wr(ADR_CTRL, 4'hF, 32'h1);
            pulse();
        end
        rd(ADR_STATUS);
        wr(5'h1F, 4'hF, 32'hCAFEF00D);
        rd(5'h1F);
        rd(5'h12);

        repeat (4) @(posedge clk_i);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d accesses never acked", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
